// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, one compare per channel,
// edge/center-aligned, shadowed config. Optional output polarity under `PWM_POLARITY_EN`.
module pwm_multi #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8,
  parameter int PRE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [PRE_WIDTH-1:0]          prescale,
  input  logic [CNT_WIDTH-1:0]          period,
  input  logic [CHANNELS*CNT_WIDTH-1:0] duty,
  input  logic                          center_mode,
`ifdef PWM_POLARITY_EN
  input  logic [CHANNELS-1:0]           polarity,
`endif
  input  logic                          cfg_wr,
  output logic                          cfg_pending,
  output logic                          period_tick,
  output logic [CHANNELS-1:0]           pwm_out
);

  typedef logic [CHANNELS-1:0][CNT_WIDTH-1:0] duty_t;

  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dir_q, dir_d;   // 1 = counting down (center mode only)
  logic [CNT_WIDTH-1:0] per_act_q, per_act_d, per_sh_q, per_sh_d;
  duty_t                duty_act_q, duty_act_d, duty_sh_q, duty_sh_d;
  logic                 ctr_act_q, ctr_act_d, ctr_sh_q, ctr_sh_d;
  logic                 pend_q, pend_d;
  logic                 ptick_q, ptick_d;
  logic [CHANNELS-1:0]  pwm_q, pwm_d;
  logic [CHANNELS-1:0]  cmp, pol_act;
  logic                 tick, bnd, apply;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign cmp[i] = cnt_q < duty_act_q[i];
  end

  always_comb begin
    // >= keeps the prescaler from running away if prescale drops below pre_q
    tick  = en && (pre_q >= prescale);
    pre_d = (!en || tick) ? '0 : pre_q + PRE_WIDTH'(1);
    cnt_d = cnt_q;
    dir_d = dir_q;
    bnd   = 1'b0;
    if (!en) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick) begin
      if (!ctr_act_q) begin
        if (cnt_q >= per_act_q) begin
          cnt_d = '0;
          bnd   = 1'b1;
        end else cnt_d = cnt_q + CNT_WIDTH'(1);
      end else if (!dir_q) begin
        if (cnt_q >= per_act_q) begin
          // period 0/1: the top is also the 1->0 step, so no down phase
          if (per_act_q <= CNT_WIDTH'(1)) begin
            cnt_d = '0;
            bnd   = 1'b1;
          end else begin
            cnt_d = per_act_q - CNT_WIDTH'(1);
            dir_d = 1'b1;
          end
        end else cnt_d = cnt_q + CNT_WIDTH'(1);
      end else begin
        if (cnt_q <= CNT_WIDTH'(1)) begin
          cnt_d = '0;
          dir_d = 1'b0;
          bnd   = 1'b1;
        end else cnt_d = cnt_q - CNT_WIDTH'(1);
      end
    end

    apply      = pend_q && (bnd || !en);
    per_act_d  = apply ? per_sh_q  : per_act_q;
    duty_act_d = apply ? duty_sh_q : duty_act_q;
    ctr_act_d  = apply ? ctr_sh_q  : ctr_act_q;
    per_sh_d   = cfg_wr ? period      : per_sh_q;
    duty_sh_d  = cfg_wr ? duty_t'(duty) : duty_sh_q;
    ctr_sh_d   = cfg_wr ? center_mode : ctr_sh_q;
    pend_d     = cfg_wr ? 1'b1 : (apply ? 1'b0 : pend_q);
    ptick_d    = bnd;
    pwm_d      = en ? (cmp ^ pol_act) : pol_act;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q      <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      per_act_q  <= '0;
      duty_act_q <= '0;
      ctr_act_q  <= 1'b0;
      per_sh_q   <= '0;
      duty_sh_q  <= '0;
      ctr_sh_q   <= 1'b0;
      pend_q     <= 1'b0;
      ptick_q    <= 1'b0;
      pwm_q      <= '0;
    end else begin
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
      ctr_act_q  <= ctr_act_d;
      per_sh_q   <= per_sh_d;
      duty_sh_q  <= duty_sh_d;
      ctr_sh_q   <= ctr_sh_d;
      pend_q     <= pend_d;
      ptick_q    <= ptick_d;
      pwm_q      <= pwm_d;
    end
  end

`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0] pol_sh_q, pol_sh_d, pol_act_q, pol_act_d;
  assign pol_sh_d  = cfg_wr ? polarity : pol_sh_q;
  assign pol_act_d = apply ? pol_sh_q : pol_act_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      pol_sh_q  <= '0;
      pol_act_q <= '0;
    end else begin
      pol_sh_q  <= pol_sh_d;
      pol_act_q <= pol_act_d;
    end
  end
  assign pol_act = pol_act_q;
`else
  assign pol_act = '0;
`endif

  assign cfg_pending = pend_q;
  assign period_tick = ptick_q;
  assign pwm_out     = pwm_q;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator with a shared prescaler and period counter, and one compare per channel. It supports edge-aligned and center-aligned modes. Period, duties and mode are written into shadow registers and become active only at a period boundary, so outputs never glitch mid-cycle. It is the parametrised successor of the single-channel 8-bit pwm and sits behind the button/sync front end or a register interface.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
CNT_WIDTH, 8, width of period counter, period and duty values
PRE_WIDTH, 16, width of prescaler reload value

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
en  in  1  run enable
prescale  in  PRE_WIDTH  tick every prescale+1 clk cycles
period  in  CNT_WIDTH  counter top value (shadowed)
duty  in  CHANNELS*CNT_WIDTH  channel i duty at bits [i*CNT_WIDTH +: CNT_WIDTH] (shadowed)
center_mode  in  1  0 = edge-aligned, 1 = center-aligned (shadowed)
cfg_wr  in  1  one-cycle pulse: capture period/duty/center_mode into shadow
cfg_pending  out  1  shadow holds values not yet applied
period_tick  out  1  one-cycle pulse at each period boundary
pwm_out  out  CHANNELS  PWM outputs, registered

Behaviour:
- Reset (rst==0 at posedge clk) clears all state:
  - prescaler, counter and direction (up) cleared.
  - active and shadow period, duty and mode all 0.
  - cfg_pending=0, period_tick=0, pwm_out=0.
- Prescaler:
  - counts 0..prescale; tick asserts in the cycle it equals prescale, then it reloads 0.
  - prescale=0 gives a tick every cycle.
  - prescale is not shadowed; a change takes effect on the next compare.
- Edge mode counter:
  - on tick, cnt increments; cnt==period on tick wraps to 0.
  - PWM period = (period+1) ticks.
  - boundary = the tick where cnt wraps period->0.
- Center mode counter:
  - counts up to period, then down to 0; direction flips at period and at 0.
  - PWM period = 2*period ticks.
  - boundary = the tick where cnt goes 1->0 while counting down.
  - period=0: cnt stays 0 and every tick is a boundary.
- Compare:
  - pwm_out[i] is registered from (cnt < duty_act[i]) and lags cnt by one clk.
  - duty 0 gives constant low.
  - edge mode: duty >= period+1 gives constant high.
  - center mode: duty > period gives constant high.
- Shadow handshake:
  - cfg_wr loads the shadow and sets cfg_pending the next cycle.
  - at a boundary with cfg_pending=1: active <= shadow, cfg_pending clears, and the new values apply from the first tick of the next period.
  - cfg_wr in the same cycle as a boundary: the boundary applies the old shadow, the new write lands in the shadow, and cfg_pending stays 1.
  - a second cfg_wr before a boundary overwrites the shadow; last write wins.
- period_tick: registered, asserts the cycle after the boundary tick, 1 clk wide.
- en=0:
  - prescaler, cnt and direction are held at 0/up.
  - pwm_out forced 0, period_tick 0.
  - shadow transfers to active the next cycle if pending.
- en rising: counting starts at cnt=0; the first boundary is one full period later.
- Reset mid-period drops every output low within the same clock edge; no partial period completes.

Optional Feature:
PWM_POLARITY_EN:
- Defined:
  - adds input port polarity [CHANNELS], captured into the shadow by cfg_wr and applied at a boundary like duty.
  - pwm_out[i] = compare XOR polarity_act[i].
  - en=0 or reset drives pwm_out[i] = polarity_act[i], the idle level; reset clears polarity to 0.
- Undefined: the port is absent and outputs are active-high as above.

Test Plan:
- Edge, CHANNELS=2, prescale=0, period=9, duty={10,3}, en=1 -> ch0 high 3 of every 10 clk, ch1 constant high, period_tick every 10 clk.
- Center, prescale=0, period=4, duty0=2 -> cnt 0,1,2,3,4,3,2,1 repeating; ch0 high for 3 of 8 clk; period_tick every 8 clk.
- prescale=3, period=1, edge, duty0=1 -> ch0 high 4 clk, low 4 clk; period_tick every 8 clk.
- Running period=9 duty0=3; cfg_wr duty0=7 mid-period -> cfg_pending=1 until the boundary; the current period keeps 3 high; the next period has 7 high; cfg_pending=0.
- cfg_wr coincident with boundary, then en=0 -> old shadow applied at the boundary, pending remains 1; after en=0 the shadow applies within 1 clk, pwm_out=0.
- rst=0 asserted mid-period -> next clk all outputs 0, cfg_pending=0; after release with en=1 and cfg_wr, output appears only after the first boundary.
